// File: rtl/xm23_pkg.sv
// ============================================================================
// Module      : xm23_pkg
// Description : Shared XM23 ALU definitions: opcode encoding, PSW bit
//               positions and the byte/word select bit of alu_op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xm23_pkg;

   // 5-bit ALU operation codes; 17..31 are unused (result = D, PSW kept)
   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_ADDC = 5'd1,
      OP_SUB  = 5'd2,
      OP_SUBC = 5'd3,
      OP_DADD = 5'd4,
      OP_CMP  = 5'd5,
      OP_XOR  = 5'd6,
      OP_AND  = 5'd7,
      OP_OR   = 5'd8,
      OP_BIT  = 5'd9,
      OP_BIC  = 5'd10,
      OP_BIS  = 5'd11,
      OP_MOV  = 5'd12,
      OP_SRA  = 5'd13,
      OP_RRC  = 5'd14,
      OP_SWPB = 5'd15,
      OP_SXT  = 5'd16
   } alu_opcode_t;

   // PSW bit positions
   localparam int PSW_C   = 0;
   localparam int PSW_Z   = 1;
   localparam int PSW_N   = 2;
   localparam int PSW_SLP = 3;
   localparam int PSW_V   = 4;

   // alu_op bit selecting byte (1) or word (0) operation
   localparam int BYTE_BIT = 5;

endpackage : xm23_pkg

`default_nettype wire

// File: rtl/xm23_bcd_adder.sv
// ============================================================================
// Module      : xm23_bcd_adder
// Description : 4-digit BCD nibble adder with carry-in and per-digit carry
//               outputs. Any digit sum above 9 is reduced by 10 and carries,
//               including sums of invalid (A..F) input digits.
//               Used only when XM23_ALU_DADD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xm23_bcd_adder (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic [3:0]  dcarry   // carry out of each digit, [3] = top digit
);

   logic [4:0] c;

   assign c[0]   = cin;
   assign dcarry = c[4:1];

   // Ripple the decimal carry through the four digits
   for (genvar i = 0; i < 4; i++) begin : g_digit
      logic [4:0] raw;
      assign raw = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c[i]};
      assign c[i+1] = (raw > 5'd9);
      assign sum[4*i +: 4] = c[i+1] ? (raw[3:0] - 4'd10) : raw[3:0];
   end

endmodule : xm23_bcd_adder

`default_nettype wire

// File: rtl/xm23_alu.sv
// ============================================================================
// Module      : xm23_alu
// Description : Registered XM23 arithmetic/logic unit. Combines S and D bus
//               operands per alu_op, registers a 16-bit result and an
//               updated PSW. One cycle latency, one operation per cycle.
//               Optional: define XM23_ALU_DADD_EN to enable BCD add (op 4);
//               otherwise op 4 behaves as an unused code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xm23_alu
   import xm23_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [15:0] s_bus,
   input  logic [15:0] d_bus,
   input  logic [5:0]  alu_op,
   input  logic [15:0] psw_in,
   input  logic        alu_E,
   input  logic        psw_update,
   output logic [15:0] alu_out,
   output logic [15:0] alu_psw_out
);

   alu_opcode_t op;
   logic        c_in;
   logic        is_byte;
   logic        add_sub;
   logic [15:0] b_opnd;
   logic        add_cin;
   logic [16:0] sum_w;
   logic [8:0]  sum_b;
   logic [15:0] add_res;
   logic        add_c;
   logic        add_v;

   logic [15:0] calc;       // value the flags are derived from
   logic [15:0] result;     // value loaded into alu_out
   logic        upd_zn, upd_c, upd_v;
   logic        c_new, v_new;
   logic        res_z, res_n;
   logic [15:0] psw_next;

   assign op   = alu_opcode_t'(alu_op[4:0]);
   assign c_in = psw_in[PSW_C];

   // SWPB and SXT always work on the full word
   assign is_byte = alu_op[BYTE_BIT] && (op != OP_SWPB) && (op != OP_SXT);

   // Shared adder for ADD/ADDC/SUB/SUBC/CMP; subtracts add the inverted S
   assign add_sub = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
   assign b_opnd  = add_sub ? ~s_bus : s_bus;
   assign add_cin = (op == OP_ADD) ? 1'b0 :
                    ((op == OP_SUB) || (op == OP_CMP)) ? 1'b1 : c_in;

   assign sum_w = {1'b0, d_bus} + {1'b0, b_opnd} + {16'd0, add_cin};
   assign sum_b = {1'b0, d_bus[7:0]} + {1'b0, b_opnd[7:0]} + {8'd0, add_cin};

   assign add_res = is_byte ? {d_bus[15:8], sum_b[7:0]} : sum_w[15:0];
   assign add_c   = is_byte ? sum_b[8] : sum_w[16];
   assign add_v   = is_byte ?
                    ((d_bus[7]  == b_opnd[7])  && (sum_b[7]  != d_bus[7])) :
                    ((d_bus[15] == b_opnd[15]) && (sum_w[15] != d_bus[15]));

`ifdef XM23_ALU_DADD_EN
   logic [15:0] bcd_sum;
   logic [3:0]  bcd_dc;

   xm23_bcd_adder u_bcd (
      .a      (d_bus),
      .b      (s_bus),
      .cin    (c_in),
      .sum    (bcd_sum),
      .dcarry (bcd_dc)
   );
`endif

   // Operation decode: result, flag source and which flags are written
   always_comb begin
      calc   = d_bus;
      upd_zn = 1'b0;
      upd_c  = 1'b0;
      upd_v  = 1'b0;
      c_new  = c_in;
      v_new  = psw_in[PSW_V];
      case (op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
            calc   = add_res;
            upd_zn = 1'b1;
            upd_c  = 1'b1;
            upd_v  = 1'b1;
            c_new  = add_c;
            v_new  = add_v;
         end
`ifdef XM23_ALU_DADD_EN
         OP_DADD: begin
            calc   = is_byte ? {d_bus[15:8], bcd_sum[7:0]} : bcd_sum;
            upd_zn = 1'b1;
            upd_c  = 1'b1;
            c_new  = is_byte ? bcd_dc[1] : bcd_dc[3];
         end
`endif
         OP_XOR: begin calc = d_bus ^ s_bus;  upd_zn = 1'b1; end
         OP_AND,
         OP_BIT: begin calc = d_bus & s_bus;  upd_zn = 1'b1; end
         OP_OR,
         OP_BIS: begin calc = d_bus | s_bus;  upd_zn = 1'b1; end
         OP_BIC: begin calc = d_bus & ~s_bus; upd_zn = 1'b1; end
         OP_MOV:  calc = s_bus;
         OP_SRA: begin
            calc   = is_byte ? {d_bus[15:8], d_bus[7], d_bus[7:1]}
                             : {d_bus[15], d_bus[15:1]};
            upd_zn = 1'b1;
            upd_c  = 1'b1;
            c_new  = d_bus[0];
         end
         OP_RRC: begin
            calc   = is_byte ? {d_bus[15:8], c_in, d_bus[7:1]}
                             : {c_in, d_bus[15:1]};
            upd_zn = 1'b1;
            upd_c  = 1'b1;
            c_new  = d_bus[0];
         end
         OP_SWPB: begin calc = {d_bus[7:0], d_bus[15:8]};    upd_zn = 1'b1; end
         OP_SXT:  begin calc = {{8{d_bus[7]}}, d_bus[7:0]}; upd_zn = 1'b1; end
         default: calc = d_bus;
      endcase

      // Logic ops work on the whole word; byte mode keeps D's upper byte
      if (is_byte) begin
         calc[15:8] = d_bus[15:8];
      end

      result = ((op == OP_CMP) || (op == OP_BIT)) ? d_bus : calc;
   end

   assign res_z = is_byte ? (calc[7:0] == 8'h00) : (calc == 16'h0000);
   assign res_n = is_byte ? calc[7] : calc[15];

   // PSW merge: untouched bits always follow psw_in
   always_comb begin
      psw_next = psw_in;
      if (psw_update) begin
         if (upd_zn) begin
            psw_next[PSW_Z] = res_z;
            psw_next[PSW_N] = res_n;
         end
         if (upd_c) psw_next[PSW_C] = c_new;
         if (upd_v) psw_next[PSW_V] = v_new;
      end
   end

   // Output registers, loaded only on enabled cycles
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         alu_out     <= 16'h0000;
         alu_psw_out <= 16'h0000;
      end else if (alu_E) begin
         alu_out     <= result;
         alu_psw_out <= psw_next;
      end
   end

endmodule : xm23_alu

`default_nettype wire

// File: tb/tb_xm23_alu.sv
// ============================================================================
// Module      : tb_xm23_alu
// Description : Directed self-checking bench for xm23_alu. Expected values
//               for op 4 follow XM23_ALU_DADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xm23_alu;

   localparam logic [5:0] A_ADD  = 6'd0;
   localparam logic [5:0] A_ADDC = 6'd1;
   localparam logic [5:0] A_SUB  = 6'd2;
   localparam logic [5:0] A_DADD = 6'd4;
   localparam logic [5:0] A_CMP  = 6'd5;
   localparam logic [5:0] A_MOV  = 6'd12;
   localparam logic [5:0] A_SRA  = 6'd13;
   localparam logic [5:0] A_RRC  = 6'd14;
   localparam logic [5:0] A_SWPB = 6'd15;
   localparam logic [5:0] A_SXT  = 6'd16;
   localparam logic [5:0] A_UNUS = 6'd20;
   localparam logic [5:0] BYTE   = 6'h20;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic [15:0] s_bus, d_bus, psw_in;
   logic [5:0]  alu_op;
   logic        alu_E, psw_update;
   logic [15:0] alu_out, alu_psw_out;

   int n_checks = 0;
   int n_errors = 0;

   xm23_alu dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .s_bus       (s_bus),
      .d_bus       (d_bus),
      .alu_op      (alu_op),
      .psw_in      (psw_in),
      .alu_E       (alu_E),
      .psw_update  (psw_update),
      .alu_out     (alu_out),
      .alu_psw_out (alu_psw_out)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply one enabled operation and sample just after the capturing edge
   task automatic run(input logic [5:0] op, input logic [15:0] d,
                      input logic [15:0] s, input logic [15:0] psw,
                      input logic upd);
      @(negedge Clock);
      alu_op = op; d_bus = d; s_bus = s; psw_in = psw;
      psw_update = upd; alu_E = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   task automatic vec(input string tag, input logic [5:0] op,
                      input logic [15:0] d, input logic [15:0] s,
                      input logic [15:0] psw, input logic upd,
                      input logic [15:0] exp_out, input logic [15:0] exp_psw);
      run(op, d, s, psw, upd);
      check({tag, "_out"}, alu_out, exp_out);
      check({tag, "_psw"}, alu_psw_out, exp_psw);
   endtask

   initial begin
      Reset_n = 1'b0; alu_E = 1'b0; psw_update = 1'b0;
      s_bus = '0; d_bus = '0; psw_in = '0; alu_op = '0;
      repeat (2) @(posedge Clock);
      #1;
      check("rst_out", alu_out, 16'h0000);
      check("rst_psw", alu_psw_out, 16'h0000);
      @(negedge Clock);
      Reset_n = 1'b1;

      //   tag          op          D        S        psw_in   upd  out      psw
      vec("add_ovf",   A_ADD,      16'h7FFF,16'h0001,16'h0000,1'b1,16'h8000,16'h0014);
      vec("add_wrap",  A_ADD,      16'hFFFF,16'h0001,16'h0000,1'b1,16'h0000,16'h0003);
      vec("sub_eq",    A_SUB,      16'h0005,16'h0005,16'h0000,1'b1,16'h0000,16'h0003);
      vec("badd",      A_ADD|BYTE, 16'h12FF,16'h0001,16'h0000,1'b1,16'h1200,16'h0003);
      vec("addc",      A_ADDC,     16'h0001,16'h0001,16'h0001,1'b1,16'h0003,16'h0000);
`ifdef XM23_ALU_DADD_EN
      vec("dadd_c1",   A_DADD,     16'h0999,16'h0000,16'h0001,1'b1,16'h1000,16'h0000);
      vec("dadd_top",  A_DADD,     16'h9999,16'h0001,16'h0000,1'b1,16'h0000,16'h0003);
`else
      vec("dadd_c1",   A_DADD,     16'h0999,16'h0000,16'h0001,1'b1,16'h0999,16'h0001);
      vec("dadd_top",  A_DADD,     16'h9999,16'h0001,16'h0000,1'b1,16'h9999,16'h0000);
`endif
      vec("rrc",       A_RRC,      16'h0002,16'h0000,16'h0001,1'b1,16'h8001,16'h0004);
      vec("sra",       A_SRA,      16'h8001,16'h0000,16'h0000,1'b1,16'hC000,16'h0005);
      vec("bsra",      A_SRA|BYTE, 16'hAB81,16'h0000,16'h0000,1'b1,16'hABC0,16'h0005);
      vec("swpb",      A_SWPB|BYTE,16'h1234,16'h0000,16'h0011,1'b1,16'h3412,16'h0011);
      vec("sxt",       A_SXT,      16'h0080,16'h0000,16'h0000,1'b1,16'hFF80,16'h0004);
      vec("noupd",     A_ADD,      16'hFFFF,16'h0001,16'h0008,1'b0,16'h0000,16'h0008);
      vec("cmp",       A_CMP,      16'h0003,16'h0004,16'h0000,1'b1,16'h0003,16'h0004);
      vec("mov",       A_MOV,      16'h1111,16'hABCD,16'h001F,1'b1,16'hABCD,16'h001F);
      vec("unused",    A_UNUS,     16'h5A5A,16'h1234,16'h0015,1'b1,16'h5A5A,16'h0015);
      vec("opaque",    A_ADD,      16'h0001,16'h0001,16'h00E8,1'b1,16'h0002,16'h00E8);

      // Hold: outputs stay put while disabled, even as inputs move
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         alu_E = 1'b0; alu_op = A_ADD; psw_update = 1'b1;
         d_bus = 16'h1000 + 16'(i); s_bus = 16'h0101; psw_in = 16'h001F;
         @(posedge Clock);
         #1;
         check("hold_out", alu_out, 16'h0002);
         check("hold_psw", alu_psw_out, 16'h00E8);
      end

      // Asynchronous reset mid-cycle clears outputs before any edge
      vec("pre_rst",   A_ADD,      16'h7FFF,16'h0001,16'h0000,1'b1,16'h8000,16'h0014);
      @(negedge Clock);
      #2;
      Reset_n = 1'b0;
      #1;
      check("arst_out", alu_out, 16'h0000);
      check("arst_psw", alu_psw_out, 16'h0000);
      @(negedge Clock);
      Reset_n = 1'b1;
      vec("post_rst",  A_SWPB,     16'h00FF,16'h0000,16'h0000,1'b1,16'hFF00,16'h0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
      $finish;
   end

endmodule : tb_xm23_alu

`default_nettype wire
